// File: rtl/bist_controller_pkg.sv
// Shared types and constants for the BIST controller: FSM state encoding,
// LFSR feedback taps and the MISR feedback polynomial.
package bist_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_FLUSH,
        ST_COMPARE,
        ST_DONE
    } state_t;

    // Feedback taps b7, b5, b4, b3 (x^8 + x^6 + x^5 + x^4 + 1)
    localparam logic [7:0]  LFSR_TAPS = 8'b1011_1000;

    // x^16 + x^12 + x^5 + 1 with the x^16 term implied
    localparam logic [15:0] MISR_POLY = 16'h1021;

    // One Fibonacci step: shift toward the MSB, parity of the taps enters bit 0
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by 8'h01
    function automatic logic [7:0] seed_or_one(input logic [7:0] seed);
        return (seed == 8'h00) ? 8'h01 : seed;
    endfunction

endpackage

// File: rtl/bist_misr.sv
// 16-bit multiple-input signature register compacting two CUT response bits
// per cycle into a running signature.
module bist_misr
    import bist_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic [1:0]  data,
    output logic [15:0] sig
);

    // Shift-and-fold signature update; clear wins over enable
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ {14'b0, data};
        end
    end

endmodule

// File: rtl/bist_controller.sv
// Logic BIST controller: holds the CUT in reset, applies LFSR patterns,
// compacts the responses in a MISR and compares against a golden signature.
// In IDLE the functional stimulus passes straight through to the CUT.
module bist_controller
    import bist_controller_pkg::*;
#(
    parameter int          N_PAT   = 30,
    parameter int          RST_CYC = 2,
    parameter logic [7:0]  SEED    = 8'h01,
    parameter logic [15:0] GOLDEN  = 16'h0000
) (
    input  logic CLK,
    input  logic RST,
    input  logic bist_start,
    input  logic in_k,
    input  logic in_j,
    input  logic in_en,
    input  logic cut_synced_d,
    input  logic cut_sync_err_d,
    output logic cut_k,
    output logic cut_j,
    output logic cut_en,
    output logic cut_rst,
    output logic pass_fail,
    output logic bist_end,
    output logic bist_busy
);

    localparam int               CNT_MAX   = (N_PAT > RST_CYC) ? N_PAT : RST_CYC;
    localparam int               CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(N_PAT - 1);
    localparam logic [7:0]       SEED_EFF  = seed_or_one(SEED);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic             start_armed;
    logic             start_rise;
    logic [7:0]       lfsr;
    logic             misr_en;
    logic             misr_clr;
    logic [15:0]      signature;

    // start_armed holds the inverse of the previous bist_start sample, so its
    // reset value of 0 means "treat bist_start as already high": a request
    // held through reset release must drop before it can start a run.
    assign start_rise = bist_start && start_armed;

    // The first RUN cycle only sees the CUT's reset response, so compaction
    // starts one cycle late and the FLUSH cycle picks up the last response.
    assign misr_en  = ((state == ST_RUN) && (cnt != '0)) || (state == ST_FLUSH);
    assign misr_clr = (state == ST_INIT);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection; requests during a run are ignored, DONE waits for bist_start low
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (start_rise)         next_state = ST_INIT;
            ST_INIT:    if (cnt == INIT_LAST)   next_state = ST_RUN;
            ST_RUN:     if (cnt == RUN_LAST)    next_state = ST_FLUSH;
            ST_FLUSH:                           next_state = ST_COMPARE;
            ST_COMPARE:                         next_state = ST_DONE;
            ST_DONE:    if (!bist_start)        next_state = ST_IDLE;
            default:                            next_state = ST_IDLE;
        endcase
    end

    // Phase cycle counter, restarted on every state change
    always_ff @(posedge CLK) begin
        if (RST || (state != next_state)) begin
            cnt <= '0;
        end else if ((state == ST_INIT) || (state == ST_RUN)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Edge-detect flop for bist_start
    always_ff @(posedge CLK) begin
        if (RST) begin
            start_armed <= 1'b0;
        end else begin
            start_armed <= !bist_start;
        end
    end

    // Pattern generator: reseeded during INIT, stepped once per RUN cycle
    always_ff @(posedge CLK) begin
        if (RST || (state == ST_INIT)) begin
            lfsr <= SEED_EFF;
        end else if (state == ST_RUN) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // Result flag: cleared at run start, updated in COMPARE, held otherwise
    always_ff @(posedge CLK) begin
        if (RST || (state == ST_INIT)) begin
            pass_fail <= 1'b0;
        end else if (state == ST_COMPARE) begin
            pass_fail <= (signature == GOLDEN);
        end
    end

    bist_misr u_misr (
        .clk  (CLK),
        .rst  (RST),
        .en   (misr_en),
        .clr  (misr_clr),
        .data ({cut_synced_d, cut_sync_err_d}),
        .sig  (signature)
    );

    // CUT stimulus mux and status outputs decoded from the state
    always_comb begin
        cut_k     = 1'b0;
        cut_j     = 1'b0;
        cut_en    = 1'b0;
        cut_rst   = 1'b0;
        bist_end  = 1'b0;
        bist_busy = 1'b1;
        case (state)
            ST_IDLE: begin
                cut_k     = in_k;
                cut_j     = in_j;
                cut_en    = in_en;
                bist_busy = 1'b0;
            end
            ST_INIT: begin
                cut_rst = 1'b1;
            end
            ST_RUN: begin
                {cut_k, cut_j, cut_en} = lfsr[2:0];
            end
            ST_DONE: begin
                bist_end  = 1'b1;
                bist_busy = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller with a small registered CUT model. Two instances
// share all stimulus: one holds the matching golden signature, the other the
// same value with bit 0 flipped.
module tb_bist_controller;

    localparam int          N_PAT   = 8;
    localparam int          RST_CYC = 2;
    localparam logic [7:0]  SEED    = 8'h01;
    // CUT model response over patterns 001,010,100,000,001,011,111,110
    // compacted from zero: 0000,0002,0006,000C,0018,0033,0067,00CE
    localparam logic [15:0] GOLD    = 16'h00CE;
    localparam int          END_LAT = RST_CYC + N_PAT + 2;

    logic CLK = 1'b0;
    logic RST;
    logic bist_start;
    logic in_k;
    logic in_j;
    logic in_en;
    logic cut_synced_d   = 1'b0;
    logic cut_sync_err_d = 1'b0;

    logic a_cut_k, a_cut_j, a_cut_en, a_cut_rst, a_pass, a_end, a_busy;
    logic b_cut_k, b_cut_j, b_cut_en, b_cut_rst, b_pass, b_end, b_busy;

    logic [2:0] pat_tab [N_PAT];
    logic [2:0] exp_q [$];
    int         total = 0;
    int         bad   = 0;
    int         end_edge;

    bist_controller #(
        .N_PAT(N_PAT), .RST_CYC(RST_CYC), .SEED(SEED), .GOLDEN(GOLD)
    ) dut_a (
        .CLK(CLK), .RST(RST), .bist_start(bist_start),
        .in_k(in_k), .in_j(in_j), .in_en(in_en),
        .cut_synced_d(cut_synced_d), .cut_sync_err_d(cut_sync_err_d),
        .cut_k(a_cut_k), .cut_j(a_cut_j), .cut_en(a_cut_en), .cut_rst(a_cut_rst),
        .pass_fail(a_pass), .bist_end(a_end), .bist_busy(a_busy)
    );

    bist_controller #(
        .N_PAT(N_PAT), .RST_CYC(RST_CYC), .SEED(SEED), .GOLDEN(GOLD ^ 16'h0001)
    ) dut_b (
        .CLK(CLK), .RST(RST), .bist_start(bist_start),
        .in_k(in_k), .in_j(in_j), .in_en(in_en),
        .cut_synced_d(cut_synced_d), .cut_sync_err_d(cut_sync_err_d),
        .cut_k(b_cut_k), .cut_j(b_cut_j), .cut_en(b_cut_en), .cut_rst(b_cut_rst),
        .pass_fail(b_pass), .bist_end(b_end), .bist_busy(b_busy)
    );

    always #5 CLK = ~CLK;

    // CUT model: one-cycle registered response, cleared by cut_rst
    always @(posedge CLK) begin
        if (a_cut_rst) begin
            cut_synced_d   <= 1'b0;
            cut_sync_err_d <= 1'b0;
        end else begin
            cut_synced_d   <= a_cut_k ^ a_cut_j;
            cut_sync_err_d <= a_cut_j & a_cut_en;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Queue the expected pattern sequence and raise bist_start
    task automatic apply_stimulus();
        for (int i = 0; i < N_PAT; i++) exp_q.push_back(pat_tab[i]);
        bist_start = 1'b1;
    endtask

    // Step edges from the start edge, scoring INIT, RUN and FLUSH cycles
    task automatic run_edges(input int stop_edge, input bit wiggle, output int done_edge);
        logic [2:0] expv;
        done_edge = -1;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (e < RST_CYC) begin
                check_output("init_cut_rst", 16'(a_cut_rst), 16'd1);
            end else if (e < RST_CYC + N_PAT) begin
                if (exp_q.size() != 0) expv = exp_q.pop_front();
                else                   expv = 3'bxxx;
                check_output("run_pattern", {13'd0, a_cut_k, a_cut_j, a_cut_en}, {13'd0, expv});
            end else if (e == RST_CYC + N_PAT) begin
                check_output("flush_outputs", {12'd0, a_busy, a_cut_k, a_cut_j, a_cut_en}, 16'b1000);
            end
            if (wiggle) begin
                if (e == 3 || e == 6) bist_start = 1'b0;
                if (e == 5 || e == 8) bist_start = 1'b1;
            end
            if (a_end) begin
                done_edge = e;
                break;
            end
            if (e == stop_edge) break;
        end
    endtask

    initial begin
        pat_tab = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b001, 3'b011, 3'b111, 3'b110};
        RST        = 1'b1;
        bist_start = 1'b1;
        in_k       = 1'b0;
        in_j       = 1'b0;
        in_en      = 1'b0;

        // Reset state
        repeat (3) tick();
        check_output("reset_busy",    16'(a_busy),    16'd0);
        check_output("reset_end",     16'(a_end),     16'd0);
        check_output("reset_pass",    16'(a_pass),    16'd0);
        check_output("reset_cut_rst", 16'(a_cut_rst), 16'd0);

        // bist_start high across reset release must not start a run
        RST = 1'b0;
        tick();
        tick();
        check_output("no_start_on_release", {14'd0, a_busy, a_cut_rst}, 16'd0);

        // IDLE passthrough in the same cycle
        bist_start = 1'b0;
        in_k = 1'b1; in_j = 1'b0; in_en = 1'b1;
        #1;
        check_output("idle_passthrough", {13'd0, a_cut_k, a_cut_j, a_cut_en}, 16'b101);
        in_k = 1'b0; in_en = 1'b0;
        tick();

        // Full run with bist_start wiggled mid-run, left high into DONE
        apply_stimulus();
        run_edges(-1, 1'b1, end_edge);
        check_output("end_latency",  16'(end_edge), 16'(END_LAT));
        check_output("pass_golden",  16'(a_pass),   16'd1);
        check_output("end_flipped",  16'(b_end),    16'd1);
        check_output("pass_flipped", 16'(b_pass),   16'd0);

        // Held bist_start must not restart
        repeat (5) tick();
        check_output("done_held", {14'd0, a_end, a_busy}, 16'b10);

        // Drop returns to IDLE with pass_fail retained
        bist_start = 1'b0;
        tick();
        check_output("idle_after_done", {13'd0, a_end, a_busy, a_pass}, 16'b001);
        tick();

        // Fresh rising edge starts again and clears pass_fail; stop in RUN cycle 3
        apply_stimulus();
        run_edges(RST_CYC + 2, 1'b0, end_edge);
        check_output("pass_cleared", 16'(a_pass), 16'd0);

        // Reset for three cycles mid-run
        RST        = 1'b1;
        bist_start = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("reset_midrun",
                         {9'd0, a_busy, a_end, a_pass, a_cut_rst, a_cut_k, a_cut_j, a_cut_en}, 16'd0);
        end
        RST = 1'b0;
        tick();
        check_output("idle_after_reset", 16'(a_busy), 16'd0);
        tick();

        // Replay from SEED gives the same patterns and signature
        apply_stimulus();
        run_edges(-1, 1'b0, end_edge);
        check_output("replay_latency", 16'(end_edge), 16'(END_LAT));
        check_output("replay_pass",    16'(a_pass),   16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bist_controller.md
BIST_CONTROLLER -- requirements
Module: bist_controller

Interface
REQ-001 Parameter N_PAT, default 30: number of test patterns applied per BIST run (>=2).
REQ-002 Parameter RST_CYC, default 2: cycles the circuit under test (CUT) is held in reset before patterns start (>=1).
REQ-003 Parameter SEED, default 8'h01: LFSR initial value.
REQ-004 Parameter GOLDEN, default 16'h0000: expected MISR signature.
REQ-005 CLK  in  1  single clock; all state updates on rising edge.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 bist_start  in  1  test request; a run starts on its rising edge.
REQ-008 in_k, in_j, in_en  in  1 each  functional stimulus from the system.
REQ-009 cut_synced_d, cut_sync_err_d  in  1 each  CUT responses.
REQ-010 cut_k, cut_j, cut_en  out  1 each  stimulus driven to the CUT.
REQ-011 cut_rst  out  1  synchronous reset to the CUT.
REQ-012 pass_fail  out  1  1 = last signature matched GOLDEN.
REQ-013 bist_end  out  1  run complete, result valid.
REQ-014 bist_busy  out  1  high in every state except IDLE and DONE.

Function
REQ-015 States: IDLE, INIT, RUN, FLUSH, COMPARE, DONE; state register, cycle counter and edge-detect flop are the only control state.
REQ-016 Rising edge of bist_start: bist_start sampled 1 while its registered previous value is 0.
REQ-017 IDLE: cut_{k,j,en} = in_{k,j,en} combinationally; cut_rst = 0; on rising edge -> INIT.
REQ-018 INIT: RST_CYC cycles; cut_rst = 1; LFSR loaded with SEED; MISR cleared to 0; pass_fail cleared to 0; counter cleared; -> RUN.
REQ-019 RUN: N_PAT cycles; {cut_k,cut_j,cut_en} = lfsr[2:0]; LFSR advances every cycle; -> FLUSH after cycle N_PAT.
REQ-020 LFSR: 8-bit Fibonacci, shift toward MSB, feedback bit0 = b7^b5^b4^b3 (x^8+x^6+x^5+x^4+1); SEED = 0 SHALL be replaced by 8'h01.
REQ-021 MISR: 16-bit, polynomial x^16+x^12+x^5+1, {cut_synced_d,cut_sync_err_d} XORed into bits [1:0]; updates in RUN cycles 2..N_PAT and in FLUSH (N_PAT samples, one-cycle CUT latency absorbed).
REQ-022 FLUSH: 1 cycle; cut inputs driven 0 -> COMPARE.
REQ-023 COMPARE: 1 cycle; pass_fail registered <= (MISR == GOLDEN) -> DONE.
REQ-024 DONE: bist_end = 1; pass_fail held; cut inputs driven 0; -> IDLE when bist_start = 0.
REQ-025 bist_end rises exactly RST_CYC+N_PAT+2 cycles after the edge where the bist_start rising edge is sampled.
REQ-026 bist_start deasserted or re-pulsed during INIT/RUN/FLUSH/COMPARE SHALL be ignored; run completes.
REQ-027 bist_start held high through DONE SHALL NOT restart; a new rising edge is required.
REQ-028 pass_fail retains its value in IDLE until the next INIT.

Reset
REQ-029 RST=1 at any state, including mid-run: state IDLE, pass_fail=0, bist_end=0, bist_busy=0, cut_rst=0, counter=0, LFSR=SEED, MISR=0, edge flop=0.
REQ-030 bist_start high while RST is released SHALL NOT start a run (edge flop cleared).

Structure
REQ-031 Shared package holds the state enum, LFSR tap and MISR polynomial constants.
REQ-032 One sub-module, bist_misr, implements the signature register (enable, clear, 2-bit data in, 16-bit out); the LFSR stays inline.

Verification
REQ-033 RST=1 for 3 cycles mid-RUN -> all outputs 0, IDLE next cycle; fresh bist_start replays from SEED.
REQ-034 IDLE, in_{k,j,en}=1,0,1 -> cut_{k,j,en}=1,0,1 in the same cycle.
REQ-035 SEED=8'h01, RST_CYC=2 -> cut_rst high 2 cycles, then {k,j,en} = 001, 010, 100 on RUN cycles 1-3.
REQ-036 N_PAT=8, RST_CYC=2, GOLDEN from reference model -> bist_end rises 12 cycles after start edge, pass_fail=1.
REQ-037 Same run, GOLDEN bit 0 flipped -> bist_end=1, pass_fail=0.
REQ-038 bist_start held high past DONE -> no second run; drop then raise -> INIT, pass_fail cleared to 0.
